// File: rtl/brq_dccm_sram_ctrl.sv
// Single-port data-memory controller between the core load/store unit and a banked SRAM.
// Accepts aligned byte/half/word accesses, sub-word stores are read-modify-write.
module brq_dccm_sram_ctrl #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 15,
    parameter int NumBanks   = 1,
    parameter int WaitStates = 0
) (
    input  logic                                       brq_clk,
    input  logic                                       brq_rst,
    input  logic                                       Data_mem_read_en,
    input  logic                                       Data_mem_write_en,
    input  logic [2:0]                                 ldst_byte_en,
    input  logic [AddrWidth-1:0]                       Data_mem_address,
    input  logic [DataWidth-1:0]                       Data_mem_dataIn,
    output logic [DataWidth-1:0]                       Data_mem_dataOut,
    output logic                                       rvalid,
    output logic                                       stall,
    output logic                                       acc_err,
    output logic [AddrWidth-2-$clog2(NumBanks)-1:0]    sram_addr,
    output logic [NumBanks-1:0]                        sram_csb,
    output logic                                       sram_web,
    output logic                                       sram_oeb,
    output logic [DataWidth-1:0]                       sram_wdata,
    input  logic [DataWidth-1:0]                       sram_rdata
);

    localparam int BankBits = $clog2(NumBanks);
    localparam int BankW    = (BankBits > 0) ? BankBits : 1;
    localparam int WordW    = AddrWidth - 2 - BankBits;
    localparam logic [2:0] WaitLast = 3'(WaitStates);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACC    = 3'd1;
    localparam logic [2:0] RMW_RD = 3'd2;
    localparam logic [2:0] RMW_WR = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    logic [2:0]           state_q, state_d;
    logic [2:0]           waitCnt_q, waitCnt_d;
    logic                 isLoad_q, isLoad_d;
    logic [1:0]           size_q, size_d;
    logic                 zext_q, zext_d;
    logic [1:0]           lane_q, lane_d;
    logic [BankW-1:0]     bank_q, bank_d;
    logic [WordW-1:0]     addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] dout_q, dout_d;
    logic                 accErr_q, accErr_d;

    logic [1:0]       reqSize;
    logic [1:0]       reqLane;
    logic [BankW-1:0] reqBank;
    logic [WordW-1:0] reqWord;
    logic             reqAny;
    logic             reqIllegal;
    logic             reqValid;
    logic             inWindow;
    logic             windowLast;

    assign reqSize = ldst_byte_en[1:0];
    assign reqLane = Data_mem_address[1:0];
    assign reqWord = Data_mem_address[2 +: WordW];
    assign reqAny  = Data_mem_read_en | Data_mem_write_en;

    if (BankBits > 0) begin : g_bank
        assign reqBank = Data_mem_address[AddrWidth-1 -: BankW];
    end else begin : g_nobank
        assign reqBank = '0;
    end

    // Misaligned, illegal-size and simultaneous load+store requests never touch the SRAM.
    assign reqIllegal = (Data_mem_read_en & Data_mem_write_en)
                      | (reqSize == 2'b11)
                      | ((reqSize == SizeHalf) & reqLane[0])
                      | ((reqSize == SizeWord) & (reqLane != 2'b00));
    assign reqValid   = reqAny & ~reqIllegal;

    assign inWindow   = (state_q == ACC) | (state_q == RMW_RD) | (state_q == RMW_WR);
    assign windowLast = (waitCnt_q == WaitLast);

    function automatic logic [DataWidth-1:0] extractLoad(
        input logic [DataWidth-1:0] rdata,
        input logic [1:0]           size,
        input logic [1:0]           lane,
        input logic                 zext
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*lane +: 8];
        h = rdata[16*lane[1] +: 16];
        case (size)
            SizeByte: extractLoad = {{(DataWidth-8){b[7] & ~zext}}, b};
            SizeHalf: extractLoad = {{(DataWidth-16){h[15] & ~zext}}, h};
            default:  extractLoad = rdata;
        endcase
    endfunction

    function automatic logic [DataWidth-1:0] mergeLanes(
        input logic [DataWidth-1:0] oldWord,
        input logic [DataWidth-1:0] data,
        input logic [1:0]           size,
        input logic [1:0]           lane
    );
        mergeLanes = oldWord;
        if (size == SizeByte) begin
            mergeLanes[8*lane +: 8] = data[7:0];
        end else begin
            mergeLanes[16*lane[1] +: 16] = data[15:0];
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        isLoad_d  = isLoad_q;
        size_d    = size_q;
        zext_d    = zext_q;
        lane_d    = lane_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dout_d    = dout_q;
        accErr_d  = 1'b0;

        if (inWindow) begin
            waitCnt_d = windowLast ? 3'd0 : waitCnt_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                accErr_d = reqAny & reqIllegal;
                if (reqValid) begin
                    isLoad_d  = Data_mem_read_en;
                    size_d    = reqSize;
                    zext_d    = ldst_byte_en[2];
                    lane_d    = reqLane;
                    bank_d    = reqBank;
                    addr_d    = reqWord;
                    wdata_d   = Data_mem_dataIn;
                    waitCnt_d = 3'd0;
                    state_d   = (Data_mem_read_en || reqSize == SizeWord) ? ACC : RMW_RD;
                end
            end
            ACC: begin
                if (windowLast) begin
                    state_d = DONE;
                    if (isLoad_q) begin
                        dout_d = extractLoad(sram_rdata, size_q, lane_q, zext_q);
                    end
                end
            end
            // The merged word replaces the raw store data so the write window drives it directly.
            RMW_RD: begin
                if (windowLast) begin
                    wdata_d = mergeLanes(sram_rdata, wdata_q, size_q, lane_q);
                    state_d = RMW_WR;
                end
            end
            RMW_WR: begin
                if (windowLast) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            state_q   <= IDLE;
            waitCnt_q <= 3'd0;
            isLoad_q  <= 1'b0;
            size_q    <= 2'b00;
            zext_q    <= 1'b0;
            lane_q    <= 2'b00;
            bank_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dout_q    <= '0;
            accErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            isLoad_q  <= isLoad_d;
            size_q    <= size_d;
            zext_q    <= zext_d;
            lane_q    <= lane_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dout_q    <= dout_d;
            accErr_q  <= accErr_d;
        end
    end

    always_comb begin
        sram_csb = '1;
        for (int b = 0; b < NumBanks; b++) begin
            sram_csb[b] = ~(inWindow & (int'(bank_q) == b));
        end
    end

    assign sram_web   = ~(((state_q == ACC) & ~isLoad_q) | (state_q == RMW_WR));
    assign sram_oeb   = ~(((state_q == ACC) &  isLoad_q) | (state_q == RMW_RD));
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    // DONE already reports completion, so the core may move on during it.
    assign stall   = ((state_q != IDLE) & (state_q != DONE)) | ((state_q == IDLE) & reqValid);
    assign rvalid  = (state_q == DONE) & isLoad_q;
    assign acc_err = accErr_q;
    assign Data_mem_dataOut = dout_q;

endmodule

// File: tb/tb_brq_dccm_sram_ctrl.sv
// Randomized self-checking bench for brq_dccm_sram_ctrl with a banked SRAM model
// and a byte-addressed reference memory.
module tb_brq_dccm_sram_ctrl;

    localparam int AW    = 15;
    localparam int NB    = 4;
    localparam int WS    = 2;
    localparam int WordW = 11;
    localparam int UsedWords = 32;

    logic              brq_clk = 1'b0;
    logic              brq_rst;
    logic              Data_mem_read_en;
    logic              Data_mem_write_en;
    logic [2:0]        ldst_byte_en;
    logic [AW-1:0]     Data_mem_address;
    logic [31:0]       Data_mem_dataIn;
    logic [31:0]       Data_mem_dataOut;
    logic              rvalid;
    logic              stall;
    logic              acc_err;
    logic [WordW-1:0]  sram_addr;
    logic [NB-1:0]     sram_csb;
    logic              sram_web;
    logic              sram_oeb;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    logic [31:0] sramMem [NB][2**WordW];
    logic [7:0]  refMem  [2**AW];

    logic             preWrEn;
    logic [1:0]       preBank;
    logic [WordW-1:0] preWord;
    logic [31:0]      preData;

    int          vectorCount;
    int          missCount;
    logic [31:0] lastLoad;
    logic [3:0]  lastCsb;

    always #5 brq_clk = ~brq_clk;

    brq_dccm_sram_ctrl #(
        .DataWidth (32),
        .AddrWidth (AW),
        .NumBanks  (NB),
        .WaitStates(WS)
    ) dut (
        .brq_clk          (brq_clk),
        .brq_rst          (brq_rst),
        .Data_mem_read_en (Data_mem_read_en),
        .Data_mem_write_en(Data_mem_write_en),
        .ldst_byte_en     (ldst_byte_en),
        .Data_mem_address (Data_mem_address),
        .Data_mem_dataIn  (Data_mem_dataIn),
        .Data_mem_dataOut (Data_mem_dataOut),
        .rvalid           (rvalid),
        .stall            (stall),
        .acc_err          (acc_err),
        .sram_addr        (sram_addr),
        .sram_csb         (sram_csb),
        .sram_web         (sram_web),
        .sram_oeb         (sram_oeb),
        .sram_wdata       (sram_wdata),
        .sram_rdata       (sram_rdata)
    );

    // SRAM model: asynchronous read while selected with oeb low, write on the clock edge.
    always_comb begin
        sram_rdata = 32'hDEAD_BEEF;
        for (int b = 0; b < NB; b++) begin
            if (!sram_csb[b] && !sram_oeb) sram_rdata = sramMem[b][sram_addr];
        end
    end

    always @(posedge brq_clk) begin
        if (preWrEn) sramMem[preBank][preWord] <= preData;
        for (int b = 0; b < NB; b++) begin
            if (!sram_csb[b] && !sram_web) sramMem[b][sram_addr] <= sram_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] refWord(input logic [AW-1:0] a);
        logic [AW-1:0] base;
        base = {a[AW-1:2], 2'b00};
        return {refMem[base + 15'd3], refMem[base + 15'd2], refMem[base + 15'd1], refMem[base]};
    endfunction

    task automatic preload(input logic [AW-1:0] addr, input logic [31:0] word);
        Data_mem_read_en  = 1'b0;
        Data_mem_write_en = 1'b0;
        preWrEn = 1'b1;
        preBank = addr[14:13];
        preWord = addr[12:2];
        preData = word;
        for (int i = 0; i < 4; i++) refMem[{addr[14:2], 2'(i)}] = word[8*i +: 8];
        @(posedge brq_clk);
        #1 preWrEn = 1'b0;
    endtask

    task automatic applyStimulus(input logic re, input logic we, input logic [2:0] be,
                                 input logic [AW-1:0] addr, input logic [31:0] data);
        logic        legal;
        logic [1:0]  sz;
        logic [31:0] expData;
        logic [3:0]  expCsb;
        logic [15:0] v;
        int          stallHigh, webLow, oebLow, badCsb, bothLow, expStall, cyc;
        bit          done;

        sz     = be[1:0];
        legal  = (re ^ we) && (sz != 2'b11) && !(sz == 2'b01 && addr[0])
                 && !(sz == 2'b10 && addr[1:0] != 2'b00);
        expCsb = ~(4'b0001 << addr[14:13]);
        expData = lastLoad;
        if (re && legal) begin
            case (sz)
                2'b00: begin
                    v = {8'h00, refMem[addr]};
                    expData = 32'(v);
                    if (!be[2] && v[7]) expData = expData | 32'hFFFF_FF00;
                end
                2'b01: begin
                    v = {refMem[addr + 15'd1], refMem[addr]};
                    expData = 32'(v);
                    if (!be[2] && v[15]) expData = expData | 32'hFFFF_0000;
                end
                default: expData = refWord(addr);
            endcase
        end
        expStall = (re || sz == 2'b10) ? 2 + WS : 3 + 2 * WS;

        @(posedge brq_clk);
        #1;
        Data_mem_read_en  = re;
        Data_mem_write_en = we;
        ldst_byte_en      = be;
        Data_mem_address  = addr;
        Data_mem_dataIn   = data;

        if (!legal) begin
            @(negedge brq_clk);
            checkOutput("err_stall", 32'(stall), 32'd0);
            checkOutput("err_csb_req", 32'(sram_csb), 32'hF);
            @(posedge brq_clk);
            #1;
            Data_mem_read_en  = 1'b0;
            Data_mem_write_en = 1'b0;
            @(negedge brq_clk);
            checkOutput("err_pulse", 32'(acc_err), 32'd1);
            checkOutput("err_csb", 32'(sram_csb), 32'hF);
            checkOutput("err_rvalid", 32'(rvalid), 32'd0);
            @(negedge brq_clk);
            checkOutput("err_pulse_end", 32'(acc_err), 32'd0);
            return;
        end

        stallHigh = 0; webLow = 0; oebLow = 0; badCsb = 0; bothLow = 0; cyc = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge brq_clk);
            cyc++;
            if (sram_csb != 4'hF) begin
                lastCsb = sram_csb;
                if (sram_csb != expCsb) badCsb++;
            end
            if (!sram_web) webLow++;
            if (!sram_oeb) oebLow++;
            if (!sram_web && !sram_oeb) bothLow++;
            if (stall) stallHigh++;
            else done = 1'b1;
        end
        if (!done) checkOutput("timeout", 32'd0, 32'd1);

        checkOutput("stall_cycles", 32'(stallHigh), 32'(expStall));
        checkOutput("web_low", 32'(webLow), re ? 32'd0 : 32'(1 + WS));
        checkOutput("oeb_low", 32'(oebLow), (re || sz != 2'b10) ? 32'(1 + WS) : 32'd0);
        checkOutput("both_low", 32'(bothLow), 32'd0);
        checkOutput("bank_sel", 32'(badCsb), 32'd0);
        checkOutput("rvalid", 32'(rvalid), 32'(re));
        checkOutput("no_err", 32'(acc_err), 32'd0);
        checkOutput("dataOut", Data_mem_dataOut, expData);

        if (re) begin
            lastLoad = expData;
        end else begin
            case (sz)
                2'b00: refMem[addr] = data[7:0];
                2'b01: begin
                    refMem[addr]          = data[7:0];
                    refMem[addr + 15'd1]  = data[15:8];
                end
                default: for (int i = 0; i < 4; i++) refMem[{addr[14:2], 2'(i)}] = data[8*i +: 8];
            endcase
        end
    endtask

    initial begin
        int          cyc;
        int          r;
        logic [1:0]  sz, lane, bank;
        logic [10:0] word;
        logic        re, we;

        vectorCount = 0;
        missCount   = 0;
        lastLoad    = 32'd0;
        lastCsb     = 4'hF;
        preWrEn     = 1'b0;
        preBank     = 2'd0;
        preWord     = '0;
        preData     = 32'd0;
        brq_rst           = 1'b1;
        Data_mem_read_en  = 1'b0;
        Data_mem_write_en = 1'b0;
        ldst_byte_en      = 3'b000;
        Data_mem_address  = '0;
        Data_mem_dataIn   = 32'd0;

        for (int b = 0; b < NB; b++) begin
            for (int w = 0; w < UsedWords; w++) begin
                preload({2'(b), 11'(w), 2'b00}, $urandom);
            end
        end

        @(negedge brq_clk);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_acc_err", 32'(acc_err), 32'd0);
        checkOutput("rst_dataOut", Data_mem_dataOut, 32'd0);
        checkOutput("rst_csb", 32'(sram_csb), 32'hF);
        checkOutput("rst_web", 32'(sram_web), 32'd1);
        checkOutput("rst_oeb", 32'(sram_oeb), 32'd1);
        checkOutput("rst_addr", 32'(sram_addr), 32'd0);
        checkOutput("rst_wdata", sram_wdata, 32'd0);
        @(posedge brq_clk);
        #1 brq_rst = 1'b0;

        // Word load, signed/unsigned byte loads.
        preload(15'h000C, 32'h8899_AABB);
        applyStimulus(1'b1, 1'b0, 3'b010, 15'h000C, 32'd0);
        checkOutput("word_load", Data_mem_dataOut, 32'h8899_AABB);
        preload(15'h0010, 32'h8011_2233);
        applyStimulus(1'b1, 1'b0, 3'b000, 15'h0013, 32'd0);
        checkOutput("byte_sext", Data_mem_dataOut, 32'hFFFF_FF80);
        applyStimulus(1'b1, 1'b0, 3'b100, 15'h0013, 32'd0);
        checkOutput("byte_zext", Data_mem_dataOut, 32'h0000_0080);

        // Half store through read-modify-write.
        preload(15'h0020, 32'h1122_3344);
        applyStimulus(1'b0, 1'b1, 3'b001, 15'h0022, 32'h0000_BEEF);
        checkOutput("half_rmw", sramMem[0][8], 32'hBEEF_3344);

        // Rejected requests.
        applyStimulus(1'b1, 1'b1, 3'b010, 15'h000C, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'b010, 15'h0002, 32'd0);

        // Top-quarter store selects only the last bank.
        lastCsb = 4'hF;
        applyStimulus(1'b0, 1'b1, 3'b010, 15'h6004, 32'h1234_5678);
        checkOutput("bank3_csb", 32'(lastCsb), 32'h7);

        // Reset in the middle of the RMW read window.
        preload(15'h0040, 32'hCAFE_F00D);
        @(posedge brq_clk);
        #1;
        Data_mem_write_en = 1'b1;
        ldst_byte_en      = 3'b000;
        Data_mem_address  = 15'h0041;
        Data_mem_dataIn   = 32'h0000_0055;
        cyc = 0;
        do begin
            @(negedge brq_clk);
            cyc++;
        end while (sram_oeb === 1'b1 && cyc < 10);
        checkOutput("rmw_rd_seen", 32'(sram_oeb), 32'd0);
        brq_rst           = 1'b1;
        Data_mem_write_en = 1'b0;
        @(posedge brq_clk);
        #1 brq_rst = 1'b0;
        lastLoad = 32'd0;
        @(negedge brq_clk);
        checkOutput("mid_rst_csb", 32'(sram_csb), 32'hF);
        checkOutput("mid_rst_web", 32'(sram_web), 32'd1);
        checkOutput("mid_rst_oeb", 32'(sram_oeb), 32'd1);
        checkOutput("mid_rst_stall", 32'(stall), 32'd0);
        checkOutput("mid_rst_dataOut", Data_mem_dataOut, 32'd0);
        repeat (8) @(negedge brq_clk);
        checkOutput("mid_rst_nowrite", sramMem[0][16], 32'hCAFE_F00D);
        applyStimulus(1'b1, 1'b0, 3'b010, 15'h0040, 32'd0);
        checkOutput("mid_rst_reload", Data_mem_dataOut, 32'hCAFE_F00D);

        // Randomized traffic over a small window of words in every bank.
        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 19);
            re = (r < 10) || (r == 0);
            we = (r >= 10) || (r == 0);
            r  = $urandom_range(0, 15);
            sz = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
            lane = 2'($urandom_range(0, 3));
            if (sz == 2'b10 && $urandom_range(0, 3) != 0) lane = 2'b00;
            if (sz == 2'b01 && $urandom_range(0, 1) != 0) lane[0] = 1'b0;
            bank = 2'($urandom_range(0, 3));
            word = 11'($urandom_range(0, UsedWords - 1));
            applyStimulus(re, we, {1'($urandom_range(0, 1)), sz}, {bank, word, lane}, $urandom);
        end
        Data_mem_read_en  = 1'b0;
        Data_mem_write_en = 1'b0;
        repeat (2) @(negedge brq_clk);

        for (int b = 0; b < NB; b++) begin
            for (int w = 0; w < UsedWords; w++) begin
                checkOutput("mem_final", sramMem[b][w], refWord({2'(b), 11'(w), 2'b00}));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
